display_scan_mux: RTL and testbench

- Parametrised, time-multiplexed driver for NUM_DIGITS seven-segment digits that share one segment bus.
- Holds a double-buffered copy of all digit codes and scans the digits at a programmable refresh rate.
- Decodes the same 16-code alphabet used elsewhere in the design and supports optional leading-zero blanking.
- Sits between processor-visible output registers (PC, register values, status letters) and the board's display pins.

---
 rtl/display_pkg.sv | 26 ++
 rtl/seg7_decode.sv | 29 ++
 rtl/display_scan_mux.sv | 110 +++++++++++
 tb/tb_display_scan_mux.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - digit code alphabet and active-high seven-segment patterns (a..g = bit6..bit0)
package display_pkg;

  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_DASH  = 4'hB;
  localparam logic [3:0] CODE_H     = 4'hC;
  localparam logic [3:0] CODE_L     = 4'hD;
  localparam logic [3:0] CODE_T     = 4'hE;

  localparam logic [6:0] SEG_0    = 7'b1111110;
  localparam logic [6:0] SEG_1    = 7'b0110000;
  localparam logic [6:0] SEG_2    = 7'b1101101;
  localparam logic [6:0] SEG_3    = 7'b1111001;
  localparam logic [6:0] SEG_4    = 7'b0110011;
  localparam logic [6:0] SEG_5    = 7'b1011011;
  localparam logic [6:0] SEG_6    = 7'b1011111;
  localparam logic [6:0] SEG_7    = 7'b1110000;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1111011;
  localparam logic [6:0] SEG_DASH = 7'b0000001;
  localparam logic [6:0] SEG_H    = 7'b0110111;
  localparam logic [6:0] SEG_L    = 7'b0001110;
  localparam logic [6:0] SEG_T    = 7'b1000110;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational 4-bit code to active-high seven-segment pattern
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  always_comb begin
    case (code)
      4'h0:      pattern = SEG_0;
      4'h1:      pattern = SEG_1;
      4'h2:      pattern = SEG_2;
      4'h3:      pattern = SEG_3;
      4'h4:      pattern = SEG_4;
      4'h5:      pattern = SEG_5;
      4'h6:      pattern = SEG_6;
      4'h7:      pattern = SEG_7;
      4'h8:      pattern = SEG_8;
      4'h9:      pattern = SEG_9;
      CODE_DASH: pattern = SEG_DASH;
      CODE_H:    pattern = SEG_H;
      CODE_L:    pattern = SEG_L;
      CODE_T:    pattern = SEG_T;
      default:   pattern = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - multiplexed seven-segment scan driver with shadow buffer and leading-zero blanking
// Optional blinking of masked digits when DISPLAY_BLINK_EN is defined.
module display_scan_mux
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1
`ifdef DISPLAY_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            load,
  input  logic [4*NUM_DIGITS-1:0]         digits_in,
  input  logic                            lzb,
`ifdef DISPLAY_BLINK_EN
  input  logic [NUM_DIGITS-1:0]           blink_mask,
`endif
  output logic [6:0]                      segments,
  output logic [NUM_DIGITS-1:0]           anodes,
  output logic [$clog2(NUM_DIGITS)-1:0]   digit_idx,
  output logic                            frame_tick
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [6:0]            SEG_IDLE = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{ACTIVE_LOW}};

  logic [PW-1:0]           presc;
  logic                    slot_tick;
  logic [IW-1:0]           next_idx;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic                    above_ok;
  logic [3:0]              scan_code;
  logic [3:0]              sel_code;
  logic [6:0]              dec_pattern;
  logic [6:0]              lit_pattern;
  logic                    blank_sel;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic                    blink_off;

  assign slot_tick = (presc == PW'(REFRESH_DIV - 1));
  assign next_idx  = (digit_idx == IW'(NUM_DIGITS - 1)) ? '0 : digit_idx + IW'(1);
  assign sel_code  = shadow[4*next_idx +: 4];

  // A zero is leading only if every higher digit is zero or a blank code.
  always_comb begin
    lz_mask   = '0;
    above_ok  = 1'b1;
    scan_code = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      scan_code = shadow[4*i +: 4];
      if (i != 0 && scan_code == 4'h0 && above_ok)
        lz_mask[i] = 1'b1;
      above_ok = above_ok && (scan_code == 4'h0 || scan_code == CODE_BLANK || scan_code == 4'hF);
    end
  end

  seg7_decode u_decode (
    .code    (sel_code),
    .pattern (dec_pattern)
  );

`ifdef DISPLAY_BLINK_EN
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  logic [FW-1:0] frame_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      frame_cnt <= '0;
    else if (frame_tick)
      frame_cnt <= frame_cnt + FW'(1);
  end

  assign blink_off = frame_cnt[FW-1];
  assign blank_sel = (lzb && lz_mask[next_idx]) || (blink_off && blink_mask[next_idx]);
`else
  assign blink_off = 1'b0;
  assign blank_sel = (lzb && lz_mask[next_idx]) || blink_off;
`endif

  assign lit_pattern = blank_sel ? SEG_OFF : dec_pattern;
  assign an_onehot   = NUM_DIGITS'(1) << next_idx;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc      <= '0;
      digit_idx  <= '0;
      shadow     <= {NUM_DIGITS{CODE_BLANK}};
      frame_tick <= 1'b0;
      segments   <= SEG_IDLE;
      anodes     <= AN_IDLE;
    end else begin
      presc      <= slot_tick ? '0 : presc + PW'(1);
      frame_tick <= slot_tick && (next_idx == '0);
      if (load)
        shadow <= digits_in;
      if (slot_tick) begin
        digit_idx <= next_idx;
        segments  <= ACTIVE_LOW ? ~lit_pattern : lit_pattern;
        anodes    <= ACTIVE_LOW ? ~an_onehot : an_onehot;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb/tb_display_scan_mux.sv - self-checking bench for display_scan_mux against a slot-level reference model
module tb_display_scan_mux;

  localparam int N  = 4;
  localparam int RD = 4;

  logic         clock;
  logic         reset_n;
  logic         load;
  logic [15:0]  digits_in;
  logic         lzb;
  logic [6:0]   segments;
  logic [3:0]   anodes;
  logic [1:0]   digit_idx;
  logic         frame_tick;

  display_scan_mux #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .digits_in  (digits_in),
    .lzb        (lzb),
    .segments   (segments),
    .anodes     (anodes),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  int          n_pass;
  int          n_total;
  int          k;
  logic [3:0]  msh [N];
  logic [6:0]  pat [16];
  logic [6:0]  exp_seg;
  logic [3:0]  exp_an;
  logic [1:0]  exp_idx;
  logic        exp_ft;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, k);
  endtask

  function automatic logic [6:0] digit_pat(input int d, input logic lz);
    logic [6:0] p;
    bit         all_lead;
    p = pat[msh[d]];
    if (lz && d != 0 && msh[d] == 4'h0) begin
      all_lead = 1'b1;
      for (int j = d + 1; j < N; j++)
        if (!(msh[j] inside {4'h0, 4'hA, 4'hF})) all_lead = 1'b0;
      if (all_lead) p = 7'b0000000;
    end
    return p;
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < N; i++) msh[i] = 4'hA;
    exp_seg = 7'h7F;
    exp_an  = 4'hF;
    exp_idx = 2'd0;
    exp_ft  = 1'b0;
  endtask

  // Slot n (n = k / RD) shows digit n mod N using the buffer as it stood before the edge.
  task automatic model_edge(input logic ld, input logic [15:0] d, input logic lz);
    int slot;
    int ni;
    k++;
    exp_ft = 1'b0;
    if (k % RD == 0) begin
      slot    = k / RD;
      ni      = slot % N;
      exp_idx = 2'(ni);
      exp_an  = ~(4'b0001 << ni);
      exp_seg = ~digit_pat(ni, lz);
      exp_ft  = (ni == 0);
    end
    if (ld)
      for (int i = 0; i < N; i++) msh[i] = d[4*i +: 4];
  endtask

  task automatic check_pins(input string tag);
    chk({tag, ".seg"}, 32'(segments), 32'(exp_seg));
    chk({tag, ".an"},  32'(anodes),   32'(exp_an));
    chk({tag, ".idx"}, 32'(digit_idx), 32'(exp_idx));
    chk({tag, ".ft"},  32'(frame_tick), 32'(exp_ft));
  endtask

  task automatic step(input logic ld, input logic [15:0] d);
    load      = ld;
    digits_in = d;
    @(posedge clock);
    model_edge(ld, d, lzb);
    #1;
    check_pins("step");
    load = 1'b0;
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    v[4*i +: 4] = 4'h0;
        2:       v[4*i +: 4] = 4'hA;
        3:       v[4*i +: 4] = 4'hF;
        default: v[4*i +: 4] = 4'($urandom);
      endcase
    end
    return v;
  endfunction

  int ft_count;
  int guard;

  initial begin
    pat[0]  = 7'b1111110; pat[1]  = 7'b0110000; pat[2]  = 7'b1101101; pat[3]  = 7'b1111001;
    pat[4]  = 7'b0110011; pat[5]  = 7'b1011011; pat[6]  = 7'b1011111; pat[7]  = 7'b1110000;
    pat[8]  = 7'b1111111; pat[9]  = 7'b1111011; pat[10] = 7'b0000000; pat[11] = 7'b0000001;
    pat[12] = 7'b0110111; pat[13] = 7'b0001110; pat[14] = 7'b1000110; pat[15] = 7'b0000000;
    n_pass = 0;
    n_total = 0;
    clock = 1'b0;
    reset_n = 1'b0;
    load = 1'b0;
    digits_in = '0;
    lzb = 1'b0;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    check_pins("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Dark for the first slot, then digit 1 lights.
    repeat (4) step(1'b0, 16'h0);
    chk("first_an", 32'(anodes), 32'h0000000D);

    step(1'b1, 16'h1234);
    ft_count = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 16'h0);
      if (frame_tick) ft_count++;
    end
    chk("ft_per_frame", 32'(ft_count), 32'd1);

    lzb = 1'b1;
    step(1'b1, 16'h0070);
    repeat (18) step(1'b0, 16'h0);
    lzb = 1'b0;
    repeat (16) step(1'b0, 16'h0);

    step(1'b1, 16'hCDEB);
    repeat (16) step(1'b0, 16'h0);

    // Load coinciding with a slot edge shows up one slot later.
    guard = 0;
    while ((k + 1) % RD != 0 && guard < 2 * RD) begin
      step(1'b0, 16'h0);
      guard++;
    end
    chk("pre_tick_guard", 32'(guard < 2 * RD), 32'd1);
    step(1'b1, 16'h5678);
    repeat (12) step(1'b0, 16'h0);

    repeat (300) begin
      lzb = 1'($urandom);
      if ($urandom_range(0, 3) == 0) step(1'b1, rand_digits());
      else step(1'b0, 16'h0);
    end

    // Asynchronous reset in the middle of digit 2's slot.
    guard = 0;
    while (!(exp_idx == 2'd2 && k % RD == 1) && guard < 4 * N * RD) begin
      step(1'b0, 16'h0);
      guard++;
    end
    chk("mid_guard", 32'(guard < 4 * N * RD), 32'd1);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_pins("async_rst");
    @(negedge clock);
    reset_n = 1'b1;
    lzb = 1'b0;
    repeat (20) step(1'b0, 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
